// File: rtl/hp_pack_pkg.sv
// hp_pack_pkg
//   Shared constants for the float pack stage: class one-hot indices
//   (as produced by the unpack/classify stage), exception flag indices
//   and a small helper that recognises the special-value classes.
package hp_pack_pkg;

  // Operand class one-hot indices
  localparam int NTYPES        = 6;
  localparam int CLS_ZERO      = 0;
  localparam int CLS_SUBNORMAL = 1;
  localparam int CLS_NORMAL    = 2;
  localparam int CLS_INFINITY  = 3;
  localparam int CLS_QNAN      = 4;
  localparam int CLS_SNAN      = 5;

  // Exception flag indices
  localparam int NEXC          = 4;
  localparam int EXC_INVALID   = 0;
  localparam int EXC_OVERFLOW  = 1;
  localparam int EXC_UNDERFLOW = 2;
  localparam int EXC_INEXACT   = 3;

  typedef logic [NTYPES-1:0] cls_t;
  typedef logic [NEXC-1:0]   exc_t;

  // True when the class vector selects a value that bypasses rounding
  function automatic logic is_special(input cls_t flags);
    return flags[CLS_SNAN] | flags[CLS_QNAN] | flags[CLS_INFINITY] | flags[CLS_ZERO];
  endfunction

endpackage

// File: rtl/hp_round_rne.sv
// hp_round_rne
//   Round-to-nearest-even decision for one significand.
//   Ports:
//     i_lsb      last kept fraction bit
//     i_g/i_r/i_s guard, round and sticky bits
//     o_inc      add one ulp to the kept significand
//     o_inexact  any discarded bit was non-zero
module hp_round_rne (
  input  logic i_lsb,
  input  logic i_g,
  input  logic i_r,
  input  logic i_s,
  output logic o_inc,
  output logic o_inexact
);

  // Round up above half, and on an exact tie only when the lsb is odd
  assign o_inc     = i_g & (i_r | i_s | i_lsb);
  assign o_inexact = i_g | i_r | i_s;

endmodule

// File: rtl/hp_pack.sv
// hp_pack
//   Packs an unpacked float (sign, unbiased exponent, significand with
//   guard/round/sticky) into {sign, exp field, fraction}. Normalises with
//   a one-bit-per-cycle shifter, denormalises tiny values, rounds to
//   nearest-even and encodes specials, behind valid/ready handshakes.
//   Ports:
//     clk, rst_n   clock; synchronous active-low reset
//     in_valid/in_ready   input handshake (ready only in IDLE, out of reset)
//     in_sign      result sign
//     in_exp       signed unbiased exponent, NEXP+2 bits
//     in_sig       NSIG+5 bits: [NSIG+4] carry, [NSIG+3] integer bit,
//                  [NSIG+2:3] fraction, [2] guard, [1] round, [0] sticky;
//                  value = in_sig / 2**(NSIG+3) * 2**in_exp
//     in_flags     class one-hot (hp_pack_pkg CLS_*)
//     out_valid/out_ready output handshake; outputs held while stalled
//     out_fp       packed result
//     out_exc      exception flags (hp_pack_pkg EXC_*)
module hp_pack
  import hp_pack_pkg::*;
#(
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [NEXP+1:0]      in_exp,
  input  logic [NSIG+4:0]      in_sig,
  input  logic [NTYPES-1:0]    in_flags,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NEXP+NSIG:0]   out_fp,
  output logic [NEXC-1:0]      out_exc
);

  localparam int W  = NSIG + 5;   // internal significand width
  localparam int EW = NEXP + 2;   // signed biased exponent width

  localparam logic signed [EW-1:0] BIAS  = EW'(2**(NEXP-1) - 1);
  localparam logic signed [EW-1:0] EMAX  = EW'(2**NEXP - 1);
  localparam logic signed [EW-1:0] ONE   = EW'(1);
  // Below this exponent every bit would end up in sticky: collapse at once
  localparam logic signed [EW-1:0] ECOLL = EW'(1 - W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_NORM  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              r_state;
  logic                    r_sign;
  logic [W-1:0]            r_sig;
  logic signed [EW-1:0]    r_e;
  logic                    r_out_valid;
  logic [NEXP+NSIG:0]      r_out_fp;
  exc_t                    r_out_exc;

  logic                    w_accept;
  logic                    w_special;
  logic [NEXP+NSIG:0]      w_spec_fp;
  exc_t                    w_spec_exc;
  logic [W-1:0]            w_shr;
  logic [W-1:0]            w_shl;
  logic                    w_inc;
  logic                    w_inexact;
  logic [NSIG+1:0]         w_mant_sum;
  logic                    w_rcarry;
  logic [NSIG:0]           w_mant_rnd;
  logic signed [EW-1:0]    w_e_rnd;
  logic [NEXP+NSIG:0]      w_rnd_fp;
  exc_t                    w_rnd_exc;

  assign in_ready  = (r_state == S_IDLE) && rst_n;
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_out_valid;
  assign out_fp    = r_out_fp;
  assign out_exc   = r_out_exc;

  // One-bit shifts; the right shift folds the dropped bit into sticky
  assign w_shr = {1'b0, r_sig[W-1:2], r_sig[1] | r_sig[0]};
  assign w_shl = {r_sig[W-2:0], 1'b0};

  // Special-value encoding, priority SNAN > QNAN > INF > ZERO
  always_comb begin
    w_special  = 1'b1;
    w_spec_fp  = '0;
    w_spec_exc = '0;
    if (in_flags[CLS_SNAN]) begin
      w_spec_fp               = {in_sign, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
      w_spec_exc[EXC_INVALID] = 1'b1;
    end else if (in_flags[CLS_QNAN]) begin
      w_spec_fp = {in_sign, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
    end else if (in_flags[CLS_INFINITY]) begin
      w_spec_fp = {in_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
    end else if (in_flags[CLS_ZERO]) begin
      w_spec_fp = {in_sign, {(NEXP+NSIG){1'b0}}};
    end else if (in_flags[CLS_NORMAL] | in_flags[CLS_SUBNORMAL]) begin
      w_special = 1'b0;
    end else begin
      // No class bit at all: deliver a signed zero rather than garbage
      w_spec_fp = {in_sign, {(NEXP+NSIG){1'b0}}};
    end
  end

  hp_round_rne u_rne (
    .i_lsb     (r_sig[3]),
    .i_g       (r_sig[2]),
    .i_r       (r_sig[1]),
    .i_s       (r_sig[0]),
    .o_inc     (w_inc),
    .o_inexact (w_inexact)
  );

  // The carry bit is always clear on entry to ROUND, so the sum's top
  // bit is exactly the rounding carry-out.
  assign w_mant_sum = {1'b0, r_sig[W-2:3]} + {{(NSIG+1){1'b0}}, w_inc};
  assign w_rcarry   = w_mant_sum[NSIG+1];
  assign w_mant_rnd = w_rcarry ? w_mant_sum[NSIG+1:1] : w_mant_sum[NSIG:0];
  assign w_e_rnd    = w_rcarry ? r_e + ONE : r_e;

  always_comb begin
    w_rnd_fp  = '0;
    w_rnd_exc = '0;
    w_rnd_exc[EXC_INEXACT] = w_inexact;
    if (w_e_rnd >= EMAX) begin
      w_rnd_fp                = {r_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
      w_rnd_exc[EXC_OVERFLOW] = 1'b1;
      w_rnd_exc[EXC_INEXACT]  = 1'b1;
    end else if (!w_mant_rnd[NSIG]) begin
      // Only reachable with e == 1: subnormal or zero
      w_rnd_fp                 = {r_sign, {NEXP{1'b0}}, w_mant_rnd[NSIG-1:0]};
      w_rnd_exc[EXC_UNDERFLOW] = w_inexact;
    end else begin
      w_rnd_fp = {r_sign, w_e_rnd[NEXP-1:0], w_mant_rnd[NSIG-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_out_fp    <= '0;
      r_out_exc   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sign <= in_sign;
            r_sig  <= in_sig;
            r_e    <= $signed(in_exp) + BIAS;
            if (w_special) begin
              r_out_fp    <= w_spec_fp;
              r_out_exc   <= w_spec_exc;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_NORM;
            end
          end
        end
        S_NORM: begin
          if (r_sig == '0) begin
            // Pin the exponent so a zero never reads as overflow
            r_e     <= ONE;
            r_state <= S_ROUND;
          end else if (r_sig[W-1]) begin
            r_sig <= w_shr;
            r_e   <= r_e + ONE;
          end else if (r_e < ONE) begin
            if (r_e < ECOLL) begin
              r_sig <= {{(W-1){1'b0}}, |r_sig};
              r_e   <= ONE;
            end else begin
              r_sig <= w_shr;
              r_e   <= r_e + ONE;
            end
          end else if (!r_sig[W-2] && (r_e > ONE)) begin
            r_sig <= w_shl;
            r_e   <= r_e - ONE;
          end else begin
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_out_fp    <= w_rnd_fp;
          r_out_exc   <= w_rnd_exc;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        default: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hp_pack.sv
// tb_hp_pack
//   Self-checking bench for hp_pack (NEXP=8, NSIG=7). Expected results
//   come from an exact-value reference model (integer scaling + RNE on the
//   remainder) and from hand-derived constant vectors.
module tb_hp_pack;
  import hp_pack_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [9:0]        in_exp;
  logic [11:0]       in_sig;
  logic [NTYPES-1:0] in_flags;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_fp;
  logic [NEXC-1:0]   out_exc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hp_pack #(.NEXP(8), .NSIG(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_sig    (in_sig),
    .in_flags  (in_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fp    (out_fp),
    .out_exc   (out_exc)
  );

  // Reference: value = sig * 2^(exp-10). Pick the result binade E (clamped
  // to the minimum normal -126), scale to a 2^(E-7) quantum, then RNE.
  function automatic void ref_pack(input logic s, input int exp, input logic [11:0] sig,
                                   input logic [NTYPES-1:0] fl,
                                   output logic [15:0] fp, output logic [3:0] exc);
    int     msb, e_unb, k, n;
    longint m, rem, half;
    bit     inx, up;
    exc = '0; fp = {s, 15'h0}; inx = 0; up = 0; m = 0;
    if (fl[CLS_SNAN]) begin
      fp = {s, 8'hFF, 7'h40}; exc[EXC_INVALID] = 1'b1;
    end else if (fl[CLS_QNAN]) begin
      fp = {s, 8'hFF, 7'h40};
    end else if (fl[CLS_INFINITY]) begin
      fp = {s, 8'hFF, 7'h00};
    end else if (fl[CLS_ZERO] || !(fl[CLS_NORMAL] || fl[CLS_SUBNORMAL]) || sig == 12'h0) begin
      fp = {s, 15'h0};
    end else begin
      msb = 0;
      for (int i = 0; i < 12; i++) if (sig[i]) msb = i;
      e_unb = msb - 10 + exp;
      if (e_unb < -126) e_unb = -126;
      if (e_unb > 127) begin
        fp = {s, 8'hFF, 7'h00}; exc[EXC_OVERFLOW] = 1'b1; exc[EXC_INEXACT] = 1'b1;
      end else begin
        k = exp - 3 - e_unb;
        if (k >= 0) begin
          m = longint'(sig) << k;
        end else begin
          n = -k;
          if (n > 40) begin
            m = 0; inx = 1;
          end else begin
            m    = longint'(sig) >> n;
            rem  = longint'(sig) & ((64'sd1 << n) - 1);
            half = 64'sd1 << (n - 1);
            inx  = (rem != 0);
            up   = (rem > half) || (rem == half && m[0]);
          end
        end
        m = m + longint'(up);
        if (m == 256) begin m = 128; e_unb++; end
        if (e_unb > 127) begin
          fp = {s, 8'hFF, 7'h00}; exc[EXC_OVERFLOW] = 1'b1; exc[EXC_INEXACT] = 1'b1;
        end else if (m < 128) begin
          fp = {s, 8'h00, m[6:0]};
          exc[EXC_UNDERFLOW] = inx; exc[EXC_INEXACT] = inx;
        end else begin
          fp = {s, 8'(e_unb + 127), m[6:0]};
          exc[EXC_INEXACT] = inx;
        end
      end
    end
  endfunction

  // Drive one operation; latency counts edges from the accept edge
  // (inclusive) to the edge that raised out_valid.
  task automatic run_op(input logic s, input int exp, input logic [11:0] sig,
                        input logic [NTYPES-1:0] fl, input bit release_out,
                        output logic [15:0] fp, output logic [3:0] exc,
                        output int lat, output bit ok);
    int guard = 0;
    ok = 1; fp = '0; exc = '0; lat = 0;
    in_sign = s; in_exp = 10'(exp); in_sig = sig; in_flags = fl; in_valid = 1'b1;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    if (!in_ready) begin ok = 0; in_valid = 1'b0; return; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!out_valid) begin ok = 0; return; end
    fp = out_fp; exc = out_exc;
    if (release_out) begin
      out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_fp !== 16'h0) begin n_bad++; $display("FAIL reset_out_fp got %h want 0000", out_fp); end
    n_cmp++; if (out_exc !== 4'h0) begin n_bad++; $display("FAIL reset_out_exc got %h want 0", out_exc); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    rst_n = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    $display("reset: out_valid=%b out_fp=%h out_exc=%h in_ready=%b", out_valid, out_fp, out_exc, in_ready);
  endtask

  task automatic test_directed();
    localparam logic [3:0] INX = 4'b1000;
    localparam logic [3:0] OVF = 4'b0010;
    localparam logic [3:0] UDF = 4'b0100;
    logic        v_s   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int          v_exp [8] = '{0, 0, 127, -130, -130, 0, -200, 50};
    logic [11:0] v_sig [8] = '{12'b0_1_0000000_000, 12'b1_1_1111111_100, 12'b0_1_1111111_110,
                               12'b0_1_0000000_000, 12'b0_1_0000000_011, 12'b0_0_0001000_000,
                               12'b0_0_0001000_000, 12'b0_0_0000000_000};
    logic [15:0] v_fp  [8] = '{16'h3F80, 16'h4080, 16'h7F80, 16'h0008, 16'h0008, 16'h3D80,
                               16'h0000, 16'h8000};
    logic [3:0]  v_exc [8] = '{4'h0, INX, OVF | INX, 4'h0, UDF | INX, 4'h0, UDF | INX, 4'h0};
    int          v_lat [8] = '{3, 4, 3, 7, 7, 7, 4, 3};
    logic [15:0] fp;
    logic [3:0]  exc;
    int          lat;
    bit          ok;
    for (int i = 0; i < 8; i++) begin
      run_op(v_s[i], v_exp[i], v_sig[i], 6'(1 << CLS_NORMAL), 1'b1, fp, exc, lat, ok);
      $display("directed %0d: exp=%0d sig=%b -> fp=%h exc=%h lat=%0d", i, v_exp[i], v_sig[i], fp, exc, lat);
      n_cmp++;
      if (!ok) begin
        n_bad++; $display("FAIL directed_%0d_timeout got no result want fp %h", i, v_fp[i]);
      end else begin
        if (fp !== v_fp[i]) begin n_bad++; $display("FAIL directed_%0d_fp got %h want %h", i, fp, v_fp[i]); end
        n_cmp++;
        if (exc !== v_exc[i]) begin n_bad++; $display("FAIL directed_%0d_exc got %h want %h", i, exc, v_exc[i]); end
        n_cmp++;
        if (lat != v_lat[i]) begin n_bad++; $display("FAIL directed_%0d_latency got %0d want %0d", i, lat, v_lat[i]); end
      end
    end
  endtask

  task automatic test_special();
    logic [NTYPES-1:0] fl;
    logic [15:0] fp, efp;
    logic [3:0]  exc, eexc;
    int          lat;
    bit          ok;
    for (int i = 0; i < 10; i++) begin
      case (i % 5)
        0: fl = 6'(1 << CLS_SNAN);
        1: fl = 6'(1 << CLS_QNAN);
        2: fl = 6'(1 << CLS_INFINITY);
        3: fl = 6'(1 << CLS_ZERO);
        default: fl = 6'((1 << CLS_SNAN) | (1 << CLS_QNAN) | (1 << CLS_ZERO));
      endcase
      ref_pack(1'(i / 5), 3, 12'h7A5, fl, efp, eexc);
      run_op(1'(i / 5), 3, 12'h7A5, fl, 1'b1, fp, exc, lat, ok);
      $display("special %0d: flags=%b sign=%0d -> fp=%h exc=%h lat=%0d", i, fl, i / 5, fp, exc, lat);
      n_cmp++;
      if (!ok) begin
        n_bad++; $display("FAIL special_%0d_timeout got no result want fp %h", i, efp);
      end else begin
        if (fp !== efp) begin n_bad++; $display("FAIL special_%0d_fp got %h want %h", i, fp, efp); end
        n_cmp++;
        if (exc !== eexc) begin n_bad++; $display("FAIL special_%0d_exc got %h want %h", i, exc, eexc); end
        n_cmp++;
        if (lat != 1) begin n_bad++; $display("FAIL special_%0d_latency got %0d want 1", i, lat); end
      end
    end
  endtask

  task automatic test_hold();
    logic [15:0] fp;
    logic [3:0]  exc;
    int          lat;
    bit          ok;
    run_op(1'b1, 0, 12'h400, 6'(1 << CLS_SNAN), 1'b0, fp, exc, lat, ok);
    n_cmp++;
    if (!ok || fp !== 16'hFFC0 || exc !== 4'b0001 || lat != 1) begin
      n_bad++; $display("FAIL hold_first got ok=%0d fp=%h exc=%h lat=%0d want fp FFC0 exc 1 lat 1", ok, fp, exc, lat);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_fp !== 16'hFFC0 || out_exc !== 4'b0001) begin
        n_bad++; $display("FAIL hold_stall_%0d got v=%b fp=%h exc=%h want v=1 fp=FFC0 exc=1", c, out_valid, out_fp, out_exc);
      end
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL hold_release got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    $display("hold: stalled 3 cycles on fp=FFC0, released, out_valid=%b in_ready=%b", out_valid, in_ready);
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    in_sign = 1'b0; in_exp = 10'd0; in_sig = 12'h001; in_flags = 6'(1 << CLS_NORMAL);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL midreset_during got v=%b rdy=%b want v=0 rdy=0", out_valid, in_ready);
    end
    rst_n = 1'b1; #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL midreset_release got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    for (int c = 0; c < 20; c++) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL midreset_discard got out_valid=1 want 0"); end
    $display("midreset: aborted op discarded, in_ready=%b", in_ready);
  endtask

  task automatic test_random();
    logic [NTYPES-1:0] fl;
    logic [15:0] fp, efp;
    logic [3:0]  exc, eexc;
    logic [11:0] sig;
    logic        s;
    int          exp, lat;
    bit          ok;
    for (int i = 0; i < 200; i++) begin
      s   = 1'($urandom);
      sig = 12'($urandom) >> $urandom_range(0, 11);
      if ($urandom_range(0, 9) == 0) exp = int'($urandom_range(0, 600)) - 300;
      else                           exp = int'($urandom_range(0, 320)) - 160;
      case ($urandom_range(0, 19))
        0:       fl = 6'(1 << CLS_SNAN);
        1:       fl = 6'(1 << CLS_QNAN);
        2:       fl = 6'(1 << CLS_INFINITY);
        3:       fl = 6'(1 << CLS_ZERO);
        4, 5, 6: fl = 6'(1 << CLS_SUBNORMAL);
        default: fl = 6'(1 << CLS_NORMAL);
      endcase
      ref_pack(s, exp, sig, fl, efp, eexc);
      run_op(s, exp, sig, fl, 1'b1, fp, exc, lat, ok);
      $display("rand %0d: s=%0d exp=%0d sig=%h flags=%b -> fp=%h exc=%h lat=%0d", i, s, exp, sig, fl, fp, exc, lat);
      n_cmp++;
      if (!ok) begin
        n_bad++; $display("FAIL rand_%0d_timeout got no result want fp %h", i, efp);
      end else begin
        if (fp !== efp) begin n_bad++; $display("FAIL rand_%0d_fp got %h want %h", i, fp, efp); end
        n_cmp++;
        if (exc !== eexc) begin n_bad++; $display("FAIL rand_%0d_exc got %h want %h", i, exc, eexc); end
        n_cmp++;
        if (lat < 1 || lat > 15) begin n_bad++; $display("FAIL rand_%0d_latency got %0d want 1..15", i, lat); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_sign = 1'b0; in_exp = '0; in_sig = '0; in_flags = '0;
    test_reset();
    test_directed();
    test_special();
    test_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
